// File: rtl/alu_cmd_ctrl.sv
// Command sequencer between the UART byte streams and the ALU: assembles
// opcode/A/B frames, issues one ALU request, returns status + result bytes.
module alu_cmd_ctrl #(
  parameter int unsigned  DATA_W         = 32,
  parameter int unsigned  NUM_OPS        = 8,
  parameter int unsigned  TIMEOUT_CYCLES = 32256,
  localparam int unsigned OPW            = $clog2(NUM_OPS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [OPW-1:0]    alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic              alu_req_valid_o,
  input  logic              alu_req_ready_i,
  input  logic              alu_rsp_valid_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_rsp_err_i,
  output logic              busy_o,
  output logic              frame_err_o
);
  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned IDXW = $clog2(2 * NB + 1);
  localparam int unsigned TXW  = $clog2(NB + 2);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_ALU_ERR = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;
  localparam logic [7:0] ST_BAD_OP  = 8'hEE;

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_ISSUE, S_WAIT, S_SEND} state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     idx_q;
  logic [OPW-1:0]      op_q;
  logic                bad_op_q;
  logic [2*DATA_W-1:0] opnd_q;
  logic [DATA_W-1:0]   res_q;
  logic [7:0]          status_q;
  logic [TXW-1:0]      tx_idx_q;
  logic [TW-1:0]       timer_q;

  logic       rx_rdy, req_vld, tx_vld, ferr;
  logic       timed_out, last_rx, last_tx, rx_acc, tx_acc;
  logic [7:0] tx_byte;

  assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES));
  assign last_rx   = (idx_q == IDXW'(2 * NB));
  assign last_tx   = bad_op_q ? (tx_idx_q == '0) : (tx_idx_q == TXW'(NB));
  assign rx_acc    = rx_valid_i && rx_rdy;
  assign tx_acc    = tx_vld && tx_ready_i;

  always_comb begin
    state_d = state_q;
    rx_rdy  = 1'b0;
    req_vld = 1'b0;
    tx_vld  = 1'b0;
    ferr    = 1'b0;
    tx_byte = 8'h00;
    case (state_q)
      S_IDLE: begin
        rx_rdy = 1'b1;
        if (rx_valid_i) state_d = S_RECV;
      end
      S_RECV: begin
        rx_rdy = 1'b1;
        // an accepted byte beats a timeout landing in the same cycle
        if (rx_valid_i) begin
          if (last_rx) state_d = bad_op_q ? S_SEND : S_ISSUE;
        end else if (timed_out) begin
          ferr    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        req_vld = 1'b1;
        if (alu_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_rsp_valid_i || timed_out) state_d = S_SEND;
      end
      S_SEND: begin
        tx_vld  = 1'b1;
        tx_byte = (tx_idx_q == '0) ? status_q : res_q[7:0];
        if (tx_ready_i && last_tx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      bad_op_q <= 1'b0;
      opnd_q   <= '0;
      res_q    <= '0;
      status_q <= '0;
      tx_idx_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q <= state_d;
      if (rx_acc || (state_d != state_q) || !(state_q inside {S_RECV, S_WAIT}))
        timer_q <= '0;
      else if (!timed_out)
        timer_q <= timer_q + TW'(1);
      case (state_q)
        S_IDLE: if (rx_acc) begin
          op_q     <= rx_data_i[OPW-1:0];
          bad_op_q <= (32'(rx_data_i) >= NUM_OPS);
          idx_q    <= IDXW'(1);
        end
        S_RECV: if (rx_acc) begin
          // bytes shift in from the top so the first operand byte lands in A[7:0]
          opnd_q <= {rx_data_i, opnd_q[2*DATA_W-1:8]};
          idx_q  <= idx_q + IDXW'(1);
          if (last_rx) begin
            status_q <= ST_BAD_OP;
            tx_idx_q <= '0;
          end
        end
        S_WAIT: begin
          tx_idx_q <= '0;
          if (alu_rsp_valid_i) begin
            status_q <= alu_rsp_err_i ? ST_ALU_ERR : ST_OK;
            res_q    <= alu_rsp_err_i ? '0 : alu_result_i;
          end else if (timed_out) begin
            status_q <= ST_TIMEOUT;
            res_q    <= '0;
          end
        end
        S_SEND: if (tx_acc) begin
          tx_idx_q <= tx_idx_q + TXW'(1);
          if (tx_idx_q != '0) res_q <= res_q >> 8;
        end
        default: ;
      endcase
    end
  end

  // handshake/pulse outputs are gated so nothing completes while reset is held
  assign rx_ready_o      = rst_ni && rx_rdy;
  assign tx_valid_o      = rst_ni && tx_vld;
  assign alu_req_valid_o = rst_ni && req_vld;
  assign frame_err_o     = rst_ni && ferr;
  assign tx_data_o       = tx_byte;
  assign busy_o          = (state_q != S_IDLE);
  assign alu_op_o        = op_q;
  assign alu_a_o         = opnd_q[DATA_W-1:0];
  assign alu_b_o         = opnd_q[2*DATA_W-1:DATA_W];
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: table of frames with expected TX bytes, plus
// sequences for RX timeout, ALU timeout, and reset mid-frame / mid-send.
module tb_alu_cmd_ctrl;
  localparam int T = 40;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [2:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic        alu_req_valid_o;
  logic        alu_req_ready_i = 1'b0;
  logic        alu_rsp_valid_i = 1'b0;
  logic [31:0] alu_result_i = '0;
  logic        alu_rsp_err_i = 1'b0;
  logic        busy_o, frame_err_o;

  always #5 clk_i = ~clk_i;

  alu_cmd_ctrl #(.DATA_W(32), .NUM_OPS(8), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_req_valid_o(alu_req_valid_o), .alu_req_ready_i(alu_req_ready_i),
    .alu_rsp_valid_i(alu_rsp_valid_i), .alu_result_i(alu_result_i),
    .alu_rsp_err_i(alu_rsp_err_i), .busy_o(busy_o), .frame_err_o(frame_err_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a, b, res;
    logic        err;
    logic        rnd;
    int          len;
    logic [39:0] exp;   // {result LE bytes, status}, byte 0 = first TX byte
  } vec_t;

  int         n_cmp = 0, n_bad = 0;
  int         req_cnt = 0, ferr_cnt = 0, stab_bad = 0;
  int         tx_mode = 1;  // 0 hold low, 1 hold high, 2 random
  logic [7:0] txq[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  vec_t       vecs[8];

  always @(posedge clk_i) begin
    #1;
    case (tx_mode)
      0:       tx_ready_i = 1'b0;
      1:       tx_ready_i = 1'b1;
      default: tx_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk_i) begin
    if (tx_valid_o && tx_ready_i) txq.push_back(tx_data_o);
    if (alu_req_valid_o && alu_req_ready_i) req_cnt++;
    if (frame_err_o) ferr_cnt++;
    if (prev_stall && rst_ni && (!tx_valid_o || tx_data_o != prev_data)) stab_bad++;
    prev_stall = tx_valid_o && !tx_ready_i;
    prev_data  = tx_data_o;
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    int n = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk_i);
    while (!rx_ready_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    if (n >= 100) check("rx_accept", 96'(rx_ready_o), 96'(1));
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    rx_byte(op);
    for (int i = 0; i < 4; i++) rx_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) rx_byte(b[8*i +: 8]);
  endtask

  task automatic check_zero(input string name);
    check(name, {16'h0, rx_ready_o, tx_valid_o, alu_req_valid_o, busy_o, frame_err_o,
                 tx_data_o, alu_op_o, alu_a_o, alu_b_o}, 96'h0);
  endtask

  // Called one #1 after the edge that accepted the last frame byte.
  task automatic finish_vec(input vec_t v);
    int n = 0;
    int r0 = req_cnt;
    @(negedge clk_i);
    if (v.len == 1) begin
      check("bad_op_first_byte", {84'h0, tx_valid_o, rx_ready_o, alu_req_valid_o, tx_data_o},
            {84'h0, 3'b100, 8'hEE});
    end else begin
      check("req_latency", {93'h0, alu_req_valid_o, rx_ready_o, busy_o}, {93'h0, 3'b101});
      check("req_fields", {29'h0, alu_op_o, alu_a_o, alu_b_o}, {29'h0, v.op[2:0], v.a, v.b});
      @(posedge clk_i); #1; alu_req_ready_i = 1'b1;
      @(posedge clk_i); #1; alu_req_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      alu_rsp_valid_i = 1'b1;
      alu_result_i    = v.res;
      alu_rsp_err_i   = v.err;
      @(posedge clk_i); #1;
      alu_rsp_valid_i = 1'b0;
      alu_rsp_err_i   = 1'b0;
      @(negedge clk_i);
      check("status_latency", {87'h0, tx_valid_o, tx_data_o}, {87'h0, 1'b1, v.exp[7:0]});
    end
    while (txq.size() < v.len && n < 300) begin
      @(posedge clk_i);
      n++;
    end
    check("tx_count", 96'(txq.size()), 96'(v.len));
    for (int i = 0; i < v.len && i < txq.size(); i++)
      check("tx_byte", 96'(txq[i]), 96'(v.exp[8*i +: 8]));
    @(negedge clk_i);
    check("idle_after_send", {94'h0, rx_ready_o, busy_o}, {94'h0, 2'b10});
    check("req_count", 96'(req_cnt - r0), 96'((v.len == 1) ? 0 : 1));
    @(posedge clk_i); #1;
  endtask

  task automatic run_vec(input vec_t v);
    txq.delete();
    tx_mode = v.rnd ? 2 : 1;
    send_frame(v.op, v.a, v.b);
    finish_vec(v);
    tx_mode = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    vec_t vb;
    int   f0, first, n;
    logic [39:0] exp_to;

    //            op     a             b             res           err   rnd   len exp
    vecs[0] = '{8'h00, 32'h00000005, 32'h00000007, 32'h0000000C, 1'b0, 1'b0, 5, 40'h0000000C_00};
    vecs[1] = '{8'h03, 32'h12345678, 32'h9ABCDEF0, 32'hA1B2C3D4, 1'b0, 1'b1, 5, 40'hA1B2C3D4_00};
    vecs[2] = '{8'h07, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 5, 40'h00000000_00};
    vecs[3] = '{8'h0F, 32'h11111111, 32'h22222222, 32'h00000000, 1'b0, 1'b0, 1, 40'h00000000_EE};
    vecs[4] = '{8'h08, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0, 1'b0, 1, 40'h00000000_EE};
    vecs[5] = '{8'h05, 32'h00000064, 32'h00000000, 32'hDEADBEEF, 1'b1, 1'b0, 5, 40'h00000000_01};
    vecs[6] = '{8'hFF, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1, 40'h00000000_EE};
    vecs[7] = '{8'h01, 32'h80000000, 32'h7FFFFFFF, 32'h11223344, 1'b0, 1'b1, 5, 40'h11223344_00};

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_zero("reset_outputs");
    @(posedge clk_i); #1; rst_ni = 1'b1;
    @(negedge clk_i);
    check("ready_after_reset", {94'h0, rx_ready_o, busy_o}, {94'h0, 2'b10});
    @(posedge clk_i); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // RX inter-byte timeout after 3 bytes, then a clean frame
    txq.delete();
    f0 = ferr_cnt;
    first = -1;
    rx_byte(8'h00); rx_byte(8'h11); rx_byte(8'h22);
    for (int k = 0; k < T + 4; k++) begin
      @(negedge clk_i);
      if (frame_err_o && first < 0) first = k;
    end
    check("rx_timeout_cycle", 96'(first), 96'(T));
    check("rx_timeout_pulses", 96'(ferr_cnt - f0), 96'(1));
    check("rx_timeout_no_tx", 96'(txq.size()), 96'(0));
    check("idle_after_rx_timeout", {94'h0, rx_ready_o, busy_o}, {94'h0, 2'b10});
    @(posedge clk_i); #1;
    run_vec(vecs[0]);

    // gaps of T-1 and exactly T idle cycles: byte arrives in time, no error
    txq.delete();
    f0 = ferr_cnt;
    rx_byte(8'h01); rx_byte(8'h03);
    repeat (T - 1) @(posedge clk_i);
    #1;
    rx_byte(8'h00);
    repeat (T) @(posedge clk_i);
    #1;
    rx_byte(8'h00); rx_byte(8'h00);
    rx_byte(8'h04); rx_byte(8'h00); rx_byte(8'h00); rx_byte(8'h00);
    vb = '{8'h01, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0, 5, 40'h00000007_00};
    finish_vec(vb);
    check("no_err_near_timeout", 96'(ferr_cnt - f0), 96'(0));

    // ALU never answers; stray response during ISSUE is ignored; random tx_ready
    txq.delete();
    tx_mode = 2;
    send_frame(8'h02, 32'h00000001, 32'h00000002);
    @(negedge clk_i);
    alu_rsp_valid_i = 1'b1;
    alu_result_i    = 32'h55;
    @(posedge clk_i); #1;
    alu_rsp_valid_i = 1'b0;
    alu_req_ready_i = 1'b1;
    @(posedge clk_i); #1;
    alu_req_ready_i = 1'b0;
    first = -1;
    for (int k = 0; k < T + 4; k++) begin
      @(negedge clk_i);
      if (tx_valid_o && first < 0) first = k;
    end
    check("alu_timeout_cycle", 96'(first), 96'(T + 1));
    n = 0;
    while (txq.size() < 5 && n < 300) begin
      @(posedge clk_i);
      n++;
    end
    exp_to = 40'h00000000_02;
    check("alu_timeout_count", 96'(txq.size()), 96'(5));
    for (int i = 0; i < 5 && i < txq.size(); i++)
      check("alu_timeout_byte", 96'(txq[i]), 96'(exp_to[8*i +: 8]));
    tx_mode = 1;
    @(posedge clk_i); #1;

    // reset mid-RECV
    rx_byte(8'h00); rx_byte(8'hAA); rx_byte(8'hBB); rx_byte(8'hCC);
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check_zero("reset_mid_recv");
    @(posedge clk_i); #1; rst_ni = 1'b1;
    @(negedge clk_i);
    check("ready_after_recv_reset", 96'(rx_ready_o), 96'(1));
    @(posedge clk_i); #1;
    run_vec(vecs[1]);

    // reset mid-SEND with the byte stalled; ready rises together with reset
    txq.delete();
    tx_mode = 0;
    send_frame(8'h04, 32'h00000009, 32'h00000001);
    @(posedge clk_i); #1; alu_req_ready_i = 1'b1;
    @(posedge clk_i); #1; alu_req_ready_i = 1'b0;
    alu_rsp_valid_i = 1'b1;
    alu_result_i    = 32'h12345678;
    @(posedge clk_i); #1;
    alu_rsp_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("send_stalled", {87'h0, tx_valid_o, tx_data_o}, {87'h0, 1'b1, 8'h00});
    tx_mode = 1;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("no_tx_during_reset", 96'(txq.size()), 96'(0));
    @(posedge clk_i);
    @(negedge clk_i);
    check_zero("reset_mid_send");
    @(posedge clk_i); #1; rst_ni = 1'b1;
    @(negedge clk_i);
    check("ready_after_send_reset", 96'(rx_ready_o), 96'(1));
    @(posedge clk_i); #1;
    run_vec(vecs[7]);

    check("tx_stability", 96'(stab_bad), 96'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
